// File: rtl/data_sync_pkg.sv
// Shared types and width helpers for the data synchronizer source-side controller.
package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ASSERT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Width of an index into n items (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/data_sync_tx_ctrl_if.sv
// Requester, synchronizer and acknowledge signals of the source-side controller.
interface data_sync_tx_ctrl_if
    import data_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned NUM_REQ   = 4
);
    localparam int unsigned GW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           done;
    logic                         busy;
    logic [GW-1:0]                grant_id;
    logic [BUS_WIDTH-1:0]         unsync_bus;
    logic                         bus_enable;
    logic                         dst_ack;
    logic                         timeout_err;

    // Controller side
    modport master (
        input  req, req_data, dst_ack,
        output done, busy, grant_id, unsync_bus, bus_enable, timeout_err
    );

    // Requester / destination side
    modport slave (
        output req, req_data, dst_ack,
        input  done, busy, grant_id, unsync_bus, bus_enable, timeout_err
    );

endinterface

// File: rtl/ack_sync.sv
// Multi-flop synchronizer bringing the destination acknowledge into the source clock.
module ack_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ack_i,
    output logic ack_o
);
    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], ack_i};
        end
    end

    assign ack_o = sync_q[STAGES-1];

endmodule

// File: rtl/data_sync_tx_ctrl.sv
// Round-robin source controller: grants one requester, holds its word on
// unsync_bus and runs a 4-phase handshake against the synchronized ack,
// with a timeout in the enable and release phases.
module data_sync_tx_ctrl
    import data_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned ACK_STAGES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic             CLK,
    input logic             RST,
    data_sync_tx_ctrl_if.master bus
);
    localparam int unsigned GW = idx_w(NUM_REQ);
    localparam int unsigned CW = cnt_w(TIMEOUT);

    logic                 ack_s;
    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 be_q, be_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [GW-1:0]        gid_q, gid_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic                 terr_q, terr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 fail_q, fail_d;

    logic [GW-1:0]        rr_cand;
    logic [GW-1:0]        rr_idx;
    logic                 rr_hit;
    logic [BUS_WIDTH-1:0] rr_word;

    ack_sync #(.STAGES(ACK_STAGES)) u_ack_sync (
        .clk_i  (CLK),
        .rst_ni (RST),
        .ack_i  (bus.dst_ack),
        .ack_o  (ack_s)
    );

    // Round-robin pick: first set request after the last granted index, wrapping.
    always_comb begin
        rr_cand = '0;
        rr_idx  = '0;
        rr_hit  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_cand = GW'((32'(ptr_q) + k) % NUM_REQ);
            if (!rr_hit && bus.req[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    assign rr_word = bus.req_data[32'(rr_idx)*BUS_WIDTH +: BUS_WIDTH];

    // Handshake sequencing: next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        be_d    = be_q;
        done_d  = '0;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        terr_d  = 1'b0;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        unique case (state_q)
            IDLE: begin
                if (rr_hit) begin
                    state_d = SETUP;
                    bus_d   = rr_word;
                    gid_d   = rr_idx;
                    ptr_d   = rr_idx;
                    cnt_d   = '0;
                    fail_d  = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_d = ASSERT;
                    be_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ASSERT: begin
                if (ack_s) begin
                    state_d = RELEASE;
                    be_d    = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RELEASE;
                    be_d    = 1'b0;
                    cnt_d   = '0;
                    terr_d  = 1'b1;
                    fail_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    if (!fail_q) begin
                        done_d[gid_q] = 1'b1;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            bus_q   <= '0;
            be_q    <= 1'b0;
            done_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= GW'(NUM_REQ - 1);
            terr_q  <= 1'b0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            be_q    <= be_d;
            done_q  <= done_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.unsync_bus  = bus_q;
    assign bus.bus_enable  = be_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.grant_id    = gid_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: doc/data_sync_tx_ctrl.md
Name: data_sync_tx_ctrl

Overview:
Source-side controller for the multi-bit data synchronizer. It arbitrates NUM_REQ requesters round-robin onto one shared unsync_bus/bus_enable channel. It holds the bus stable and runs a 4-phase level handshake against an acknowledge returned from the destination domain. A timeout recovers the channel if the acknowledge never arrives.

Parameters:
BUS_WIDTH, 8, width of each requester's data word and of unsync_bus
NUM_REQ, 4, number of requesters (>=2)
SETUP_CYC, 2, cycles unsync_bus is stable before bus_enable rises (>=1)
ACK_STAGES, 2, flop stages synchronizing dst_ack (>=2)
TIMEOUT, 255, max cycles waited in ASSERT or RELEASE; counter width $clog2(TIMEOUT+1)

Ports:
CLK  in  1  source clock
RST  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester
req_data  in  NUM_REQ*BUS_WIDTH  requester i data at [i*BUS_WIDTH +: BUS_WIDTH]
done  out  NUM_REQ  one-cycle pulse: requester's word acknowledged
busy  out  1  channel in use (state != IDLE)
grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
unsync_bus  out  BUS_WIDTH  data to synchronizer, registered
bus_enable  out  1  level enable to synchronizer, registered
dst_ack  in  1  asynchronous ack level from destination domain
timeout_err  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (async, RST=0): state=IDLE; unsync_bus=0, bus_enable=0, done=0, busy=0, grant_id=0, timeout_err=0. RR pointer=NUM_REQ-1, so requester 0 has first priority. Counter=0. Ack sync flops=0.
- Reset mid-transaction aborts immediately. bus_enable drops asynchronously. No done or timeout_err.
- dst_ack passes through ACK_STAGES flops to give ack_s. All handshake decisions use ack_s only.
- States: IDLE, SETUP, ASSERT, RELEASE. All outputs are registered.
- IDLE:
  - If any req is set, grant the first set bit searching from pointer+1 with wrap.
  - Next cycle: SETUP, unsync_bus=req_data[granted], grant_id=granted, pointer=granted, busy=1, counter=0.
  - With no req, the state stays IDLE and unsync_bus holds its last value.
- SETUP:
  - Counter increments each cycle.
  - After SETUP_CYC cycles in SETUP, go to ASSERT with bus_enable=1 and counter=0.
  - First bus_enable=1 cycle = SETUP_CYC+1 cycles after the IDLE cycle that granted.
- ASSERT:
  - If ack_s=1, go to RELEASE with bus_enable=0 and counter=0.
  - Else, if counter==TIMEOUT-1, go to RELEASE with bus_enable=0, counter=0, timeout_err pulse, and the transaction flagged failed.
  - Else the counter increments.
- RELEASE:
  - If ack_s=0, go to IDLE with busy=0; done[grant_id] pulses in that same cycle unless the transaction is flagged failed.
  - Else, if counter==TIMEOUT-1, go to IDLE with a timeout_err pulse and no done.
  - A timeout in ASSERT followed by a timeout in RELEASE produces two separate pulses.
- unsync_bus stays constant from SETUP entry until the next grant. req_data changes after grant are ignored.
- Requester dropping req mid-transaction: the transaction still completes and done still pulses. The requester is responsible for not re-requesting the same word.
- A failed transaction issues no done. A still-asserted req re-arbitrates normally, and the RR pointer has already advanced past it.
- Back-to-back: the minimum is one IDLE cycle between RELEASE and the next SETUP.
- Simultaneous ack_s and timeout on the same cycle: ack wins, no error.
- done is one-hot or zero.

Decomposition:
- Shared package data_sync_pkg: state enum/localparams (IDLE=0, SETUP=1, ASSERT=2, RELEASE=3) and the clog2-based width helper constants.
- Sub-module ack_sync:
  - ACK_STAGES-deep single-bit synchronizer.
  - Same CLK/RST, async active-low reset to 0.
- RR arbiter logic stays inline.

Test Plan:
- Single request:
  - Stimulus: req=0001, data0=8'hA5, SETUP_CYC=2; dst_ack follows bus_enable after 3 cycles.
  - Required: unsync_bus=A5 one cycle after the grant; bus_enable rises 3 cycles after the grant cycle; done[0] pulses once after ack falls and is seen low; busy returns to 0.
- Round-robin:
  - Stimulus: req=1111 held; dst_ack model echoes bus_enable.
  - Required: grant_id sequence 0,1,2,3,0; each unsync_bus equals the corresponding data word; no requester starves.
- Data stability:
  - Stimulus: change req_data[0] every cycle after the grant.
  - Required: unsync_bus constant through SETUP/ASSERT/RELEASE; the captured value is the one at the grant cycle.
- Timeout:
  - Stimulus: TIMEOUT=16, dst_ack tied 0.
  - Required: bus_enable high exactly 16 cycles, then 0; one timeout_err pulse; no done; state returns to IDLE; the held req is re-granted afterwards.
- Stuck ack:
  - Stimulus: dst_ack tied 1 after first rise.
  - Required: RELEASE times out after TIMEOUT cycles; timeout_err pulse; no done.
- Reset mid-ASSERT:
  - Stimulus: drop RST while bus_enable=1.
  - Required: bus_enable=0, busy=0 and unsync_bus=0 immediately without waiting for a clock edge; after reset release, requester 0 has top priority.
